if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register, drives the instruction-memory request, and holds the IF/ID pipeline register that feeds the decode stage (`instr`, `o_PCplus4`). It accepts stall from the hazard unit and redirects from decode: a taken branch, or a jump built from decode's 28-bit `jBranch` field. A small FSM handles variable-latency memory, fetches that land while decode is stalled, and in-flight fetches that a redirect makes stale.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `stall`  in  1  decode stalled; hold IF/ID.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  redirect to jump target.
- `jBranch`  in  32  instr_index<<2 from decode; bits [27:0] used.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; word-aligned.
- `imem_ready`  in  1  `imem_rdata` valid this cycle; completes the request.
- `imem_rdata`  in  32  fetched word.
- `instr`  out  32  IF/ID instruction; 0 (nop) when invalid.
- `o_PCplus4`  out  32  IF/ID PC+4 of `instr`.
- `if_valid`  out  1  IF/ID holds a real instruction.

## Operation
- Registers: `pc`, `stale_addr`, `buf_instr`, `buf_pc4`, IF/ID (`instr`, `o_PCplus4`, `if_valid`), 2-bit state.
- FSM states: FETCH, HOLD, DISCARD.
- `imem_req` = 1 in FETCH and DISCARD, 0 in HOLD and during reset.
- `imem_addr` = `pc` in FETCH and HOLD, `stale_addr` in DISCARD.
- Memory may take any number of cycles. A request completes in the cycle `imem_req` and `imem_ready` are both high.
- Address stays stable until completion. Only one request is outstanding at a time.
- Redirect = `jump | branch_taken`. Target when `jump` = {`o_PCplus4`[31:28], `jBranch`[27:2], 2'b00}. Otherwise target = {`branch_target`[31:2], 2'b00}. Jump wins if both are asserted.
- Priority: reset > redirect > stall > normal. A redirect is applied even if `stall` is high.
- Redirect, any state:
  - `pc` <= target.
  - IF/ID <= bubble (`instr`=0, `o_PCplus4`=0, `if_valid`=0).
  - Hold buffer discarded.
  - If in FETCH with no completion this cycle: `stale_addr` <= `pc`, go DISCARD.
  - If in DISCARD with no completion: stay DISCARD.
  - Otherwise: go FETCH. A word completing in the redirect cycle is dropped.
- FETCH, completion, !stall: IF/ID <= {`imem_rdata`, `pc`+4, 1}; `pc` <= `pc`+4.
- FETCH, completion, stall: `buf_instr`/`buf_pc4` <= `imem_rdata`/`pc`+4; `pc` <= `pc`+4; IF/ID held; go HOLD.
- FETCH, no completion: if !stall, IF/ID <= bubble; if stall, IF/ID held.
- HOLD: if stall, everything held. If !stall, IF/ID <= {`buf_instr`, `buf_pc4`, 1}, go FETCH.
- DISCARD: completion goes to FETCH, response dropped. IF/ID <= bubble if !stall, else held.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, IF/ID bubble, `imem_req`=0 while `rst` is high, `imem_addr`=RESET_PC.
- First request is issued in the first cycle after `rst` deasserts.
- Zero-wait memory (`imem_ready`=1 combinationally): one instruction per cycle. Word at address A appears on `instr` one cycle after its request, with `o_PCplus4`=A+4.
- Redirect takes effect next cycle: `imem_addr`=target in that cycle if the state is FETCH. Exactly one wrong-path slot is bubbled.
- `imem_req`/`imem_addr` are decoded from registered state only, with no combinational path from `imem_ready`. IF/ID outputs are registered.

## Test plan
- Reset, zero-wait memory holding word k = 32'h1000_0000+k: `imem_addr` steps 0,4,8. `instr` shows 32'h1000_0000, 32'h1000_0001, …, `o_PCplus4` = 4, 8, …, `if_valid`=1 from cycle 2.
- Memory with 3-cycle latency: each instruction is followed by 2 bubbles (`instr`=0, `if_valid`=0). `imem_addr` stays constant while waiting.
- Stall asserted on the cycle word @8 completes, held 2 cycles: IF/ID keeps word @4 and state is HOLD. After release, `instr` = word @8 and the next request address is 12. No word is lost or duplicated.
- `branch_taken`=1, `branch_target`=32'h0000_0103 while zero-wait: next `imem_addr`=32'h100, IF/ID bubble for one cycle, then word @0x100.
- 3-cycle memory, `jump` asserted one cycle after request @0x20 issued, `o_PCplus4`=32'h4000_0010, `jBranch`=32'h0000_0040: `imem_addr` stays 0x20 until completion (DISCARD). That word never reaches IF/ID; the next request is 32'h4000_0040.
- `rst` pulsed mid-wait in HOLD: asynchronous return to RESET_PC with IF/ID bubble and `imem_req`=0 immediately.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request at a
// time, and holds the IF/ID register. Handles stalls, redirects and stale in-flight fetches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jBranch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] o_PCplus4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '0;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  ifid_t       ifid_q, ifid_d;

  logic        done;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_bits;

  // Request side depends only on registered state (and reset), never on imem_ready.
  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = (state_q == DISCARD) ? stale_addr_q : pc_q;

  assign done     = imem_req && imem_ready;
  assign redirect = jump || branch_taken;
  assign target   = jump ? {ifid_q.pc4[31:28], jBranch[27:2], 2'b00}
                         : {branch_target[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign unused_bits = ^{jBranch[31:28], jBranch[1:0], branch_target[1:0]};

  assign instr     = ifid_q.instr;
  assign o_PCplus4 = ifid_q.pc4;
  assign if_valid  = ifid_q.valid;

  // NOTE: every signal gets its hold value first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_d       = ifid_q;

    if (redirect) begin
      pc_d   = target;
      ifid_d = BUBBLE;
      if (state_q == FETCH && !done) begin
        // The outstanding wrong-path request must still be completed and dropped.
        stale_addr_d = pc_q;
        state_d      = DISCARD;
      end else if (state_q == DISCARD && !done) begin
        state_d = DISCARD;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (done) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end else begin
              ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};
            end
          end else if (!stall) begin
            ifid_d = BUBBLE;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_d  = '{instr: buf_instr_q, pc4: buf_pc4_q, valid: 1'b1};
            state_d = FETCH;
          end
        end
        DISCARD: begin
          if (done) state_d = FETCH;
          if (!stall) ifid_d = BUBBLE;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= '0;
      buf_instr_q  <= '0;
      buf_pc4_q    <= '0;
      ifid_q       <= BUBBLE;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
      ifid_q       <= ifid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a variable-latency memory and a transaction-level
// model (PC, stale-request flag, hold queue, IF/ID slot) predict every output.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jBranch = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] o_PCplus4;
  logic        if_valid;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jBranch(jBranch),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .o_PCplus4(o_PCplus4), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } slot_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  slot_t       m_hold[$];
  slot_t       m_ifid;

  // Memory model state
  logic        mem_busy;
  int          mem_wait;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_req();
    return !rst && (m_hold.size() == 0);
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale ? m_stale_addr : m_pc;
  endfunction

  task automatic check_outputs();
    check("imem_req",  {31'd0, imem_req}, {31'd0, exp_req()});
    check("imem_addr", imem_addr, exp_addr());
    check("instr",     instr, m_ifid.instr);
    check("pcplus4",   o_PCplus4, m_ifid.pc4);
    check("if_valid",  {31'd0, if_valid}, {31'd0, m_ifid.valid});
  endtask

  task automatic model_reset();
    m_pc         = RESET_PC;
    m_stale      = 1'b0;
    m_stale_addr = '0;
    m_hold.delete();
    m_ifid       = '{instr: 32'd0, pc4: 32'd0, valid: 1'b0};
    mem_busy     = 1'b0;
    mem_wait     = 0;
  endtask

  // One clock: check outputs, drive this cycle's inputs, advance the model.
  task automatic step(input logic s, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jb);
    logic        req, rdy, done;
    logic [31:0] addr, tgt;
    slot_t       bubble;
    bubble = '{instr: 32'd0, pc4: 32'd0, valid: 1'b0};
    @(negedge clk);
    cyc++;
    check_outputs();
    req  = exp_req();
    addr = exp_addr();
    if (req && !mem_busy) begin
      mem_busy = 1'b1;
      mem_wait = $urandom_range(lat_max, lat_min);
    end
    rdy  = req ? (mem_wait == 0) : 1'($urandom);
    done = req && rdy;

    stall         = s;
    branch_taken  = br;
    branch_target = bt;
    jump          = j;
    jBranch       = jb;
    imem_ready    = rdy;
    imem_rdata    = word(imem_addr);

    if (j || br) begin
      tgt = j ? {m_ifid.pc4[31:28], jb[27:2], 2'b00} : {bt[31:2], 2'b00};
      m_ifid = bubble;
      m_hold.delete();
      if (req && !done) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_pc = tgt;
    end else if (m_stale) begin
      if (done) m_stale = 1'b0;
      if (!s) m_ifid = bubble;
    end else if (m_hold.size() != 0) begin
      if (!s) m_ifid = m_hold.pop_front();
    end else if (done) begin
      if (s) m_hold.push_back('{instr: word(addr), pc4: m_pc + 32'd4, valid: 1'b1});
      else   m_ifid = '{instr: word(addr), pc4: m_pc + 32'd4, valid: 1'b1};
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_ifid = bubble;
    end

    if (done) mem_busy = 1'b0;
    else if (mem_busy && mem_wait > 0) mem_wait--;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Zero-wait streaming
    repeat (8) idle_step();
    // Stall landing on a completion, held two cycles
    repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (4) idle_step();
    // Branch with unaligned target bits
    step(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'd0);
    repeat (4) idle_step();

    // Three-cycle memory, then a jump one cycle after a request is issued
    lat_min = 2;
    lat_max = 2;
    repeat (10) idle_step();
    for (int i = 0; i < 10; i++) begin
      if (mem_busy && mem_wait == 1) break;
      idle_step();
    end
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0040);
    repeat (8) idle_step();

    // Random traffic: all latencies, stalls and redirects mixed
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(3, 0) == 0),
           ($urandom_range(9, 0) == 0), $urandom,
           ($urandom_range(19, 0) == 0), $urandom);
    end

    // Reach HOLD with zero-wait memory, then reset asynchronously mid-cycle
    lat_max = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m_stale && m_hold.size() == 0 && !mem_busy) break;
      idle_step();
    end
    repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_req",   {31'd0, imem_req}, 32'd0);
    check("rst_async_addr",  imem_addr, RESET_PC);
    check("rst_async_instr", instr, 32'd0);
    check("rst_async_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    repeat (6) idle_step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
